// File: rtl/div_int_arbiter.sv
// Round-robin front end that shares one div_int divider between NUM_REQ requesters.
// Operands are latched on grant; results come back on a shared bus tagged by rsp_id.
module div_int_arbiter #(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 2,
  localparam int IDXW   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_x,
  input  logic [NUM_REQ*WIDTH-1:0] req_y,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_q,
  output logic [WIDTH-1:0]         rsp_r,
  output logic                     rsp_dbz,
  output logic [IDXW-1:0]          rsp_id,
  output logic                     div_start,
  output logic [WIDTH-1:0]         div_x,
  output logic [WIDTH-1:0]         div_y,
  input  logic                     div_busy,
  input  logic                     div_valid,
  input  logic                     div_dbz,
  input  logic [WIDTH-1:0]         div_q,
  input  logic [WIDTH-1:0]         div_r
);

  // IDLE: grant | ISSUE: start pulse | WAIT: divider running | RESP: result strobe
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic [IDXW-1:0]  ptr;
  logic [IDXW-1:0]  owner;
  logic [IDXW-1:0]  sel;
  logic             sel_hit;
  logic [WIDTH-1:0] sel_x;
  logic [WIDTH-1:0] sel_y;

  function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return sum[IDXW-1:0];
  endfunction

  // Scan downward so the candidate closest to ptr is the one left in sel.
  always_comb begin
    sel     = ptr;
    sel_hit = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_add(ptr, k)]) begin
        sel     = wrap_add(ptr, k);
        sel_hit = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && !rst && sel_hit) req_ready[sel] = 1'b1;
  end

  assign sel_x = req_x[int'(sel) * WIDTH +: WIDTH];
  assign sel_y = req_y[int'(sel) * WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      rsp_valid <= '0;
      rsp_q     <= '0;
      rsp_r     <= '0;
      rsp_dbz   <= 1'b0;
      rsp_id    <= '0;
      div_start <= 1'b0;
      div_x     <= '0;
      div_y     <= '0;
    end else begin
      div_start <= 1'b0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (sel_hit) begin
            div_x     <= sel_x;
            div_y     <= sel_y;
            owner     <= sel;
            ptr       <= wrap_add(sel, 1);
            div_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (!div_busy) begin
            rsp_q            <= div_q;
            rsp_r            <= div_r;
            rsp_dbz          <= div_dbz;
            rsp_id           <= owner;
            rsp_valid[owner] <= 1'b1;
            state            <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && state == WAIT && !div_busy && !div_valid && !div_dbz)
      $error("div_int_arbiter: divider dropped busy without valid or dbz");
  end
`endif

endmodule

// File: doc/div_int_arbiter.md
Name: div_int_arbiter

Overview:
- Shares one `div_int` integer divider instance between NUM_REQ independent requesters.
- Arbitrates round-robin and captures the operands of the granted requester.
- Sequences the divider's start/busy/valid handshake, then returns quotient, remainder and divide-by-zero status to the requester that issued the operation.
- Sits between requesting blocks and a single `div_int` instance; all divider ports connect directly to this block.

Parameters:
- WIDTH, 4, operand/result width; must equal the attached `div_int` WIDTH.
- NUM_REQ, 2, number of requesters, 2..8.
- IDXW, $clog2(NUM_REQ), width of the requester index (derived, not overridden).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester operation request
- req_ready  out  NUM_REQ  per-requester accept; handshake completes when req_valid[i] & req_ready[i]
- req_x  in  NUM_REQ*WIDTH  dividends, requester i at [i*WIDTH +: WIDTH]
- req_y  in  NUM_REQ*WIDTH  divisors, same packing
- rsp_valid  out  NUM_REQ  one-cycle result strobe to owning requester
- rsp_q  out  WIDTH  quotient (shared bus, qualified by rsp_valid)
- rsp_r  out  WIDTH  remainder (shared bus)
- rsp_dbz  out  1  divide-by-zero flag (shared bus)
- rsp_id  out  IDXW  index of requester owning current response
- div_start  out  1  to `div_int` start
- div_x  out  WIDTH  to `div_int` x
- div_y  out  WIDTH  to `div_int` y
- div_busy  in  1  from `div_int` busy
- div_valid  in  1  from `div_int` valid
- div_dbz  in  1  from `div_int` dbz
- div_q  in  WIDTH  from `div_int` q
- div_r  in  WIDTH  from `div_int` r

Behaviour:
- Reset (synchronous, rst=1 at rising edge):
  - state=IDLE; rr pointer=0.
  - req_ready=0 for all requesters while rst is high.
  - rsp_valid=0, rsp_q=0, rsp_r=0, rsp_dbz=0, rsp_id=0.
  - div_start=0, div_x=0, div_y=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Select the first i with req_valid[i]=1, searching from the rr pointer upward with wrap-around.
  - req_ready is one-hot combinational: only the selected i, only in IDLE.
  - On handshake: latch x/y into div_x/div_y, latch i into the owner register, set pointer=(i+1) mod NUM_REQ, go to ISSUE.
  - With no request pending: stay in IDLE; pointer unchanged.
- ISSUE: div_start=1 for exactly one cycle; div_x/div_y stable; go to WAIT.
- WAIT:
  - div_start=0; div_x/div_y held stable for the whole operation.
  - Stay while div_busy=1.
  - On the first cycle in WAIT with div_busy=0:
    - capture div_q, div_r, div_dbz;
    - set rsp_valid[owner]=1 and rsp_id=owner on the next cycle;
    - go to RESP.
  - A first WAIT cycle with div_busy=0 is legal (divider finished or flagged dbz immediately) and completes normally.
- RESP:
  - rsp_valid one-hot for exactly one cycle.
  - rsp_q/rsp_r/rsp_dbz/rsp_id hold their value until the next response.
  - Return to IDLE; a new grant is possible in the same cycle the FSM is back in IDLE.
- Result rules:
  - With rsp_dbz=1, rsp_q and rsp_r are don't-care; the bench must not check them.
  - div_valid is captured only for assertion: a response with div_valid=0 and div_dbz=0 is a divider protocol error (simulation-only $error).
- Latency: accept cycle T; rsp_valid at T+3+B, where B is the number of cycles div_busy stays high after start.
- Throughput: one operation outstanding at a time; no queueing.
- Fairness:
  - A continuously requesting requester waits at most NUM_REQ-1 operations.
  - Simultaneous requests are served in pointer order.
- Requester obligations:
  - Hold req_valid and operands stable until req_ready.
  - Deasserting req_valid before the handshake is legal; the request is simply not taken.
- Reset mid-operation: abort immediately to IDLE.
  - No rsp_valid is issued for the aborted operation.
  - div_start=0.
  - The `div_int` instance must share rst, so the divider is aborted too.

Test Plan:
- Single op, WIDTH=4: req0 x=7 y=2 -> exactly one rsp_valid[0] pulse, rsp_q=3, rsp_r=1, rsp_dbz=0, rsp_id=0; div_start high exactly one cycle.
- Divide by zero: req1 x=2 y=0 -> rsp_valid[1], rsp_dbz=1, rsp_id=1; FSM back in IDLE within one cycle after the response.
- Contention: req0 (15/5) and req1 (8/9) asserted in the same cycle after reset:
  - req0 is served first: q=3, r=0.
  - req1 is served next: q=0, r=8.
  - Each gets only its own rsp_valid bit.
- Round-robin fairness, NUM_REQ=2: both requesters hold req_valid for 6 operations -> grants alternate 0,1,0,1,0,1; no requester granted twice in a row while the other waits.
- Reset mid-operation: assert rst during WAIT of 1/1 -> no rsp_valid and div_start=0 afterwards; the next request 1/1 after reset yields q=1, r=0 from requester 0 (pointer reset).
- Back-to-back single requester: req0 issues 0/2 then 7/2 with req_valid held -> results q=0 r=0 then q=3 r=1; the second accept occurs in the first IDLE cycle after RESP.
